// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared types for the 68000 bus controller: decoded regions and sequencer states.
package system_consts;

  typedef enum logic [3:0] {
    REG_NONE, REG_ROM, REG_WORK, REG_SCREEN, REG_OBJECT, REG_COLOR,
    REG_IO, REG_SOUND, REG_EXT, REG_SS_SAVE, REG_SS_RESET, REG_SS_VEC
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_ROM_WAIT, ST_WS_WAIT,
    ST_PERIPH_WAIT, ST_ACK, ST_ERR, ST_DRAIN
  } bus_state_t;

  localparam int unsigned CNT_W = 8;

  function automatic logic is_periph(region_t r);
    return (r == REG_SOUND) || (r == REG_EXT);
  endfunction

endpackage

// File: rtl/bus_region_encode.sv
// Priority encoder from active-low decoder selects to the bus region code.
module bus_region_encode
  import system_consts::*;
(
  input  logic    rom_sel_n,
  input  logic    work_sel_n,
  input  logic    screen_sel_n,
  input  logic    color_sel_n,
  input  logic    io_sel_n,
  input  logic    object_sel_n,
  input  logic    sound_sel_n,
  input  logic    ext_sel_n,
  input  logic    ss_save_n,
  input  logic    ss_reset_n,
  input  logic    ss_vec_n,
  output region_t region
);

  // Save-state selects overlay the normal map, so they win over everything.
  always_comb begin
    region = REG_NONE;
    if      (!ss_reset_n)   region = REG_SS_RESET;
    else if (!ss_vec_n)     region = REG_SS_VEC;
    else if (!ss_save_n)    region = REG_SS_SAVE;
    else if (!rom_sel_n)    region = REG_ROM;
    else if (!work_sel_n)   region = REG_WORK;
    else if (!screen_sel_n) region = REG_SCREEN;
    else if (!object_sel_n) region = REG_OBJECT;
    else if (!color_sel_n)  region = REG_COLOR;
    else if (!io_sel_n)     region = REG_IO;
    else if (!sound_sel_n)  region = REG_SOUND;
    else if (!ext_sel_n)    region = REG_EXT;
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 68000 bus cycle sequencer: ROM fetch handshake, wait states, peripheral waits,
// DTACK/BERR generation with timeout and abort handling.
module cpu_bus_ctrl
  import system_consts::*;
#(
  parameter int unsigned WS_FAST  = 1,
  parameter int unsigned WS_COLOR = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_as_n,
  input  logic [1:0]  cpu_ds_n,
  input  logic        cpu_rw,
  input  logic [23:0] cpu_word_addr,
  input  logic        rom_sel_n,
  input  logic        work_sel_n,
  input  logic        screen_sel_n,
  input  logic        color_sel_n,
  input  logic        io_sel_n,
  input  logic        object_sel_n,
  input  logic        sound_sel_n,
  input  logic        ext_sel_n,
  input  logic        ss_save_n,
  input  logic        ss_reset_n,
  input  logic        ss_vec_n,
  input  logic        periph_dtack_n,
  input  logic        rom_ack,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output region_t     region,
  output logic        busy
);

  bus_state_t       state;
  region_t          dec_region;
  logic [CNT_W-1:0] ws_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] ws_sel;
  logic             cyc_start;
  logic             tmo_hit;

  bus_region_encode u_encode (
    .rom_sel_n    (rom_sel_n),
    .work_sel_n   (work_sel_n),
    .screen_sel_n (screen_sel_n),
    .color_sel_n  (color_sel_n),
    .io_sel_n     (io_sel_n),
    .object_sel_n (object_sel_n),
    .sound_sel_n  (sound_sel_n),
    .ext_sel_n    (ext_sel_n),
    .ss_save_n    (ss_save_n),
    .ss_reset_n   (ss_reset_n),
    .ss_vec_n     (ss_vec_n),
    .region       (dec_region)
  );

  assign cyc_start = !cpu_as_n && !(&cpu_ds_n);
  assign ws_sel    = (dec_region == REG_COLOR) ? CNT_W'(WS_COLOR) : CNT_W'(WS_FAST);
  // One bit of headroom so the compare stays correct when the counter is saturated.
  assign tmo_hit   = ({1'b0, tmo_cnt} + (CNT_W+1)'(1)) >= (CNT_W+1)'(TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cpu_dtack_n <= 1'b1;
      cpu_berr_n  <= 1'b1;
      rom_req     <= 1'b0;
      rom_addr    <= '0;
      region      <= REG_NONE;
      busy        <= 1'b0;
      ws_cnt      <= '0;
      tmo_cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cyc_start) begin
            state <= ST_DECODE;
            busy  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cpu_as_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            region  <= dec_region;
            tmo_cnt <= '0;
            if (dec_region == REG_ROM && cpu_rw) begin
              rom_req  <= 1'b1;
              rom_addr <= cpu_word_addr;
              state    <= ST_ROM_WAIT;
            end else if (is_periph(dec_region)) begin
              state <= ST_PERIPH_WAIT;
            end else if (ws_sel == '0) begin
              cpu_dtack_n <= 1'b0;
              state       <= ST_ACK;
            end else begin
              ws_cnt <= ws_sel - CNT_W'(1);
              state  <= ST_WS_WAIT;
            end
          end
        end
        ST_ROM_WAIT: begin
          // An abort must never leave the SDRAM handshake half-open.
          if (cpu_as_n) begin
            if (rom_ack) begin
              rom_req <= 1'b0;
              state   <= ST_IDLE;
              busy    <= 1'b0;
              region  <= REG_NONE;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (rom_ack) begin
            rom_req     <= 1'b0;
            cpu_dtack_n <= 1'b0;
            state       <= ST_ACK;
          end else if (tmo_hit) begin
            cpu_berr_n <= 1'b0;
            state      <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_WS_WAIT: begin
          if (cpu_as_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            region <= REG_NONE;
          end else if (ws_cnt == '0) begin
            cpu_dtack_n <= 1'b0;
            state       <= ST_ACK;
          end else begin
            ws_cnt <= ws_cnt - CNT_W'(1);
          end
        end
        ST_PERIPH_WAIT: begin
          if (cpu_as_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            region <= REG_NONE;
          end else if (!periph_dtack_n) begin
            cpu_dtack_n <= 1'b0;
            state       <= ST_ACK;
          end else if (tmo_hit) begin
            cpu_berr_n <= 1'b0;
            state      <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          if (cpu_as_n) begin
            cpu_dtack_n <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            region      <= REG_NONE;
          end
        end
        ST_ERR: begin
          if (rom_ack) rom_req <= 1'b0;
          if (cpu_as_n) begin
            cpu_berr_n <= 1'b1;
            if (rom_req && !rom_ack) begin
              state <= ST_DRAIN;
            end else begin
              state  <= ST_IDLE;
              busy   <= 1'b0;
              region <= REG_NONE;
            end
          end
        end
        ST_DRAIN: begin
          if (rom_ack) begin
            rom_req <= 1'b0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
            region  <= REG_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed scenarios plus randomized back-to-back cycles.
module tb_cpu_bus_ctrl;
  import system_consts::*;

  localparam int WS_FAST  = 1;
  localparam int WS_COLOR = 2;
  localparam int TIMEOUT  = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_as_n;
  logic [1:0]  cpu_ds_n;
  logic        cpu_rw;
  logic [23:0] cpu_word_addr;
  logic        rom_sel_n, work_sel_n, screen_sel_n, color_sel_n, io_sel_n, object_sel_n;
  logic        sound_sel_n, ext_sel_n, ss_save_n, ss_reset_n, ss_vec_n;
  logic        periph_dtack_n;
  logic        rom_ack;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        cpu_dtack_n;
  logic        cpu_berr_n;
  region_t     region;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int both_low = 0;

  // Priority order of the select lines, highest first; act[i] asserts entry i.
  region_t prio [11] = '{REG_SS_RESET, REG_SS_VEC, REG_SS_SAVE, REG_ROM, REG_WORK, REG_SCREEN,
                         REG_OBJECT, REG_COLOR, REG_IO, REG_SOUND, REG_EXT};

  cpu_bus_ctrl #(.WS_FAST(WS_FAST), .WS_COLOR(WS_COLOR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n), .cpu_rw(cpu_rw),
    .cpu_word_addr(cpu_word_addr), .rom_sel_n(rom_sel_n), .work_sel_n(work_sel_n),
    .screen_sel_n(screen_sel_n), .color_sel_n(color_sel_n), .io_sel_n(io_sel_n),
    .object_sel_n(object_sel_n), .sound_sel_n(sound_sel_n), .ext_sel_n(ext_sel_n),
    .ss_save_n(ss_save_n), .ss_reset_n(ss_reset_n), .ss_vec_n(ss_vec_n),
    .periph_dtack_n(periph_dtack_n), .rom_ack(rom_ack), .rom_req(rom_req), .rom_addr(rom_addr),
    .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .region(region), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic region_t ref_region(input logic [10:0] act);
    for (int i = 0; i < 11; i++) if (act[i]) return prio[i];
    return REG_NONE;
  endfunction

  // Edge (counted from AS low, DECODE at edge 1) on which DTACK is first seen low.
  function automatic int ref_dtack_edge(input region_t r, input logic rw, input int ack_k, input int per_p);
    if (r == REG_ROM && rw) return 3 + ack_k;
    if (r == REG_SOUND || r == REG_EXT) return 3 + per_p;
    return 2 + ((r == REG_COLOR) ? WS_COLOR : WS_FAST);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sels(input logic [10:0] act);
    {ext_sel_n, sound_sel_n, io_sel_n, color_sel_n, object_sel_n, screen_sel_n,
     work_sel_n, rom_sel_n, ss_save_n, ss_vec_n, ss_reset_n} = ~act;
  endtask

  // Runs one CPU cycle and reports what was observed; callers do the comparisons.
  task automatic run_access(input logic [10:0] act, input logic rw, input logic [23:0] addr,
                            input int ack_k, input int per_p, input int hold,
                            output int req_rise, output int req_fall, output int dtack_at,
                            output int berr_at, output logic [23:0] addr_seen,
                            output region_t reg_seen, output int hold_bad,
                            output logic rel_dtack_n, output logic rel_berr_n, output logic rel_busy);
    int  n;
    bit  done;
    req_rise = -1; req_fall = -1; dtack_at = -1; berr_at = -1;
    addr_seen = '0; reg_seen = REG_NONE; hold_bad = 0;
    set_sels(act);
    cpu_rw = rw;
    cpu_word_addr = addr;
    cpu_ds_n = 2'($urandom_range(0, 2));
    cpu_as_n = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      rom_ack = (req_rise >= 0 && ack_k >= 0 && n == req_rise + ack_k);
      periph_dtack_n = !(per_p >= 0 && n >= 2 + per_p);
      step();
      n++;
      if (rom_req && req_rise < 0) begin req_rise = n; addr_seen = rom_addr; end
      if (!rom_req && req_rise >= 0 && req_fall < 0) req_fall = n;
      if (!cpu_dtack_n && !cpu_berr_n) both_low++;
      if (!cpu_dtack_n && dtack_at < 0) begin dtack_at = n; reg_seen = region; end
      if (!cpu_berr_n && berr_at < 0) begin berr_at = n; reg_seen = region; end
      done = (dtack_at >= 0 || berr_at >= 0);
    end
    rom_ack = 1'b0;
    periph_dtack_n = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if (!cpu_dtack_n && !cpu_berr_n) both_low++;
      if (dtack_at >= 0 && cpu_dtack_n) hold_bad++;
      if (berr_at >= 0 && cpu_berr_n) hold_bad++;
    end
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    step();
    rel_dtack_n = cpu_dtack_n;
    rel_berr_n  = cpu_berr_n;
    rel_busy    = busy;
  endtask

  task automatic test_reset();
    checks++; if (cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL reset_dtack: got %b expected 1", cpu_dtack_n); end
    checks++; if (cpu_berr_n !== 1'b1) begin failures++; $display("FAIL reset_berr: got %b expected 1", cpu_berr_n); end
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", rom_req); end
    checks++; if (rom_addr !== 24'h0) begin failures++; $display("FAIL reset_addr: got %h expected 000000", rom_addr); end
    checks++; if (region !== REG_NONE) begin failures++; $display("FAIL reset_region: got %0d expected %0d", region, REG_NONE); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rom_read();
    int rr, rf, dt, be, hb;
    logic [23:0] as;
    region_t rs;
    logic rd, rb, ry;
    run_access(11'b000_0000_1000, 1'b1, 24'h000100, 5, -1, 2, rr, rf, dt, be, as, rs, hb, rd, rb, ry);
    checks++; if (rr !== 2) begin failures++; $display("FAIL rom_req_rise: got %0d expected 2", rr); end
    checks++; if (as !== 24'h000100) begin failures++; $display("FAIL rom_addr: got %h expected 000100", as); end
    checks++; if (rf !== 8) begin failures++; $display("FAIL rom_req_fall: got %0d expected 8", rf); end
    checks++; if (dt !== 8) begin failures++; $display("FAIL rom_dtack_edge: got %0d expected 8", dt); end
    checks++; if (rs !== REG_ROM) begin failures++; $display("FAIL rom_region: got %0d expected %0d", rs, REG_ROM); end
    checks++; if (hb !== 0) begin failures++; $display("FAIL rom_dtack_hold: got %0d expected 0", hb); end
    checks++; if (rd !== 1'b1 || ry !== 1'b0) begin failures++; $display("FAIL rom_release: got dtack_n=%b busy=%b expected 1 0", rd, ry); end
  endtask

  task automatic test_ws_regions();
    logic [10:0] acts [3] = '{11'b000_1000_0000, 11'b000_0001_0000, 11'b000_0000_0000};
    logic        rws  [3] = '{1'b0, 1'b1, 1'b1};
    logic [23:0] adrs [3] = '{24'h440010, 24'h100000, 24'h700000};
    int          exps [3] = '{4, 3, 3};
    region_t     regs [3] = '{REG_COLOR, REG_WORK, REG_NONE};
    for (int i = 0; i < 3; i++) begin
      int rr, rf, dt, be, hb;
      logic [23:0] as;
      region_t rs;
      logic rd, rb, ry;
      run_access(acts[i], rws[i], adrs[i], -1, -1, 1, rr, rf, dt, be, as, rs, hb, rd, rb, ry);
      checks++; if (dt !== exps[i]) begin failures++; $display("FAIL ws_dtack_edge[%0d]: got %0d expected %0d", i, dt, exps[i]); end
      checks++; if (rs !== regs[i]) begin failures++; $display("FAIL ws_region[%0d]: got %0d expected %0d", i, rs, regs[i]); end
      checks++; if (rr !== -1) begin failures++; $display("FAIL ws_no_req[%0d]: got %0d expected -1", i, rr); end
    end
  endtask

  task automatic test_priority();
    int rr, rf, dt, be, hb;
    logic [23:0] as;
    region_t rs;
    logic rd, rb, ry;
    run_access(11'b000_0000_1001, 1'b1, 24'h000200, 0, -1, 0, rr, rf, dt, be, as, rs, hb, rd, rb, ry);
    checks++; if (rs !== REG_SS_RESET) begin failures++; $display("FAIL prio_region: got %0d expected %0d", rs, REG_SS_RESET); end
    checks++; if (rr !== -1) begin failures++; $display("FAIL prio_no_req: got %0d expected -1", rr); end
    checks++; if (dt !== 2 + WS_FAST) begin failures++; $display("FAIL prio_dtack_edge: got %0d expected %0d", dt, 2 + WS_FAST); end
  endtask

  task automatic test_timeout();
    int rr, rf, dt, be, hb;
    logic [23:0] as;
    region_t rs;
    logic rd, rb, ry;
    run_access(11'b010_0000_0000, 1'b1, 24'h800000, -1, -1, 2, rr, rf, dt, be, as, rs, hb, rd, rb, ry);
    checks++; if (be !== 2 + TIMEOUT) begin failures++; $display("FAIL tmo_berr_edge: got %0d expected %0d", be, 2 + TIMEOUT); end
    checks++; if (dt !== -1) begin failures++; $display("FAIL tmo_no_dtack: got %0d expected -1", dt); end
    checks++; if (rs !== REG_SOUND) begin failures++; $display("FAIL tmo_region: got %0d expected %0d", rs, REG_SOUND); end
    checks++; if (hb !== 0) begin failures++; $display("FAIL tmo_berr_hold: got %0d expected 0", hb); end
    checks++; if (rb !== 1'b1 || ry !== 1'b0) begin failures++; $display("FAIL tmo_release: got berr_n=%b busy=%b expected 1 0", rb, ry); end
  endtask

  task automatic test_abort();
    int  wait_n;
    int  dtack_seen;
    dtack_seen = 0;
    set_sels(11'b000_0000_1000);
    cpu_rw = 1'b1;
    cpu_word_addr = 24'h012340;
    cpu_ds_n = 2'b00;
    cpu_as_n = 1'b0;
    step(); step();
    checks++; if (rom_req !== 1'b1) begin failures++; $display("FAIL abort_req_up: got %b expected 1", rom_req); end
    step(); step();
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    step();
    checks++; if (rom_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL abort_drain: got req=%b busy=%b expected 1 1", rom_req, busy); end
    set_sels(11'b000_0001_0000);
    cpu_as_n = 1'b0;
    cpu_ds_n = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!cpu_dtack_n) dtack_seen++;
    end
    checks++; if (dtack_seen !== 0 || rom_req !== 1'b1) begin failures++; $display("FAIL abort_held: got dtack_cycles=%0d req=%b expected 0 1", dtack_seen, rom_req); end
    rom_ack = 1'b1;
    step();
    rom_ack = 1'b0;
    checks++; if (rom_req !== 1'b0 || cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL abort_drain_exit: got req=%b dtack_n=%b expected 0 1", rom_req, cpu_dtack_n); end
    wait_n = 0;
    while (cpu_dtack_n && wait_n < 20) begin step(); wait_n++; end
    checks++; if (wait_n !== 3) begin failures++; $display("FAIL abort_next_dtack: got %0d expected 3", wait_n); end
    checks++; if (region !== REG_WORK) begin failures++; $display("FAIL abort_next_region: got %0d expected %0d", region, REG_WORK); end
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    step();
    checks++; if (cpu_dtack_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_release: got dtack_n=%b busy=%b expected 1 0", cpu_dtack_n, busy); end
  endtask

  task automatic test_async_reset();
    set_sels(11'b000_0000_1000);
    cpu_rw = 1'b1;
    cpu_word_addr = 24'h000400;
    cpu_ds_n = 2'b00;
    cpu_as_n = 1'b0;
    step(); step(); step();
    checks++; if (rom_req !== 1'b1) begin failures++; $display("FAIL areset_pre_req: got %b expected 1", rom_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rom_req !== 1'b0 || cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL areset_async: got req=%b dtack_n=%b berr_n=%b busy=%b expected 0 1 1 0", rom_req, cpu_dtack_n, cpu_berr_n, busy); end
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || rom_req !== 1'b0) begin failures++; $display("FAIL areset_idle: got busy=%b req=%b expected 0 0", busy, rom_req); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 30; it++) begin
      logic [10:0] act;
      logic        rw;
      logic [23:0] addr;
      int          ack_k, per_p, hold, mode, exp_dt;
      region_t     exp_r;
      int rr, rf, dt, be, hb;
      logic [23:0] as;
      region_t rs;
      logic rd, rb, ry;
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      act = '0;
      else if (mode == 3) act = 11'($urandom);
      else                act = 11'(1) << $urandom_range(0, 10);
      rw    = 1'($urandom);
      addr  = 24'($urandom);
      ack_k = int'($urandom_range(0, 6));
      per_p = int'($urandom_range(0, 6));
      hold  = int'($urandom_range(0, 2));
      exp_r = ref_region(act);
      exp_dt = ref_dtack_edge(exp_r, rw, ack_k, per_p);
      run_access(act, rw, addr, ack_k, per_p, hold, rr, rf, dt, be, as, rs, hb, rd, rb, ry);
      checks++; if (rs !== exp_r) begin failures++; $display("FAIL b2b_region[%0d]: got %0d expected %0d", it, rs, exp_r); end
      checks++; if (dt !== exp_dt) begin failures++; $display("FAIL b2b_dtack_edge[%0d]: got %0d expected %0d", it, dt, exp_dt); end
      checks++; if (be !== -1) begin failures++; $display("FAIL b2b_no_berr[%0d]: got %0d expected -1", it, be); end
      if (exp_r == REG_ROM && rw) begin
        checks++; if (rr !== 2 || rf !== exp_dt) begin failures++; $display("FAIL b2b_req_window[%0d]: got %0d..%0d expected 2..%0d", it, rr, rf, exp_dt); end
        checks++; if (as !== addr) begin failures++; $display("FAIL b2b_rom_addr[%0d]: got %h expected %h", it, as, addr); end
      end else begin
        checks++; if (rr !== -1) begin failures++; $display("FAIL b2b_no_req[%0d]: got %0d expected -1", it, rr); end
      end
      checks++; if (hb !== 0) begin failures++; $display("FAIL b2b_hold[%0d]: got %0d expected 0", it, hb); end
      checks++; if (rd !== 1'b1 || rb !== 1'b1 || ry !== 1'b0) begin failures++; $display("FAIL b2b_release[%0d]: got dtack_n=%b berr_n=%b busy=%b expected 1 1 0", it, rd, rb, ry); end
    end
    checks++; if (both_low !== 0) begin failures++; $display("FAIL both_strobes: got %0d expected 0", both_low); end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    cpu_rw = 1'b1;
    cpu_word_addr = '0;
    set_sels('0);
    periph_dtack_n = 1'b1;
    rom_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_rom_read();
    test_ws_regions();
    test_priority();
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Sequences every 68000 bus cycle after the address decoder has produced its active-low region selects.
- Issues ROM fetch requests to the SDRAM port using a req/ack handshake.
- Inserts per-region wait states and waits on slow peripherals (sound comm, extension).
- Drives DTACK/BERR back to the CPU; sits between the CPU core, the address decoder and the memory/peripheral fabric.

Parameters:
- WS_FAST, 1, wait cycles before DTACK for WORK/SCREEN/OBJECT/IO/SS regions and unmapped accesses
- WS_COLOR, 2, wait cycles before DTACK for the COLOR region
- TIMEOUT, 255, max cycles spent waiting on rom_ack or periph_dtack_n before BERR (8-bit counter)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_as_n  in  1  68000 address strobe
- cpu_ds_n  in  2  68000 data strobes {UDS,LDS}
- cpu_rw  in  1  1=read
- cpu_word_addr  in  24  CPU address, same as decoder input
- rom_sel_n, work_sel_n, screen_sel_n, color_sel_n, io_sel_n, object_sel_n, sound_sel_n, ext_sel_n, ss_save_n, ss_reset_n, ss_vec_n  in  1 each  decoder region selects
- periph_dtack_n  in  1  ready from sound/extension logic
- rom_ack  in  1  one-cycle SDRAM completion pulse
- rom_req  out  1  level request to SDRAM
- rom_addr  out  24  latched cpu_word_addr for ROM fetch
- cpu_dtack_n  out  1  to CPU
- cpu_berr_n  out  1  to CPU
- region  out  4  encoded region of current cycle (region_t), valid while busy
- busy  out  1  cycle in progress

Behaviour:
- Reset (async, reset_n=0): state IDLE; cpu_dtack_n=1, cpu_berr_n=1, rom_req=0, rom_addr=0, region=REG_NONE, busy=0; counters cleared.
- Cycle start: in IDLE, the first clk edge with cpu_as_n=0 and ~&cpu_ds_n goes to DECODE; busy=1.
- DECODE (1 cycle, lets the selects settle):
  - Samples the selects with priority ss_reset_n > ss_vec_n > ss_save_n > rom_sel_n > work > screen > object > color > io > sound > ext.
  - No select active gives REG_NONE, treated as a fast access (open bus).
- States: IDLE, DECODE, ROM_WAIT, WS_WAIT, PERIPH_WAIT, ACK, ERR, DRAIN.
- ROM:
  - DECODE->ROM_WAIT; rom_addr latched and rom_req=1 on the same edge.
  - rom_req is held until the rom_ack cycle and drops on the following edge; that edge goes to ACK.
  - A write to ROM gets no rom_req and is acked via WS_FAST.
- WS_WAIT: count down WS_FAST (or WS_COLOR for COLOR) from the DECODE exit; count 0 goes straight to ACK. Latency from DECODE to dtack low = WS+1 cycles.
- PERIPH_WAIT (sound, ext): goes to ACK on the first cycle periph_dtack_n=0.
- Timeout:
  - ROM_WAIT/PERIPH_WAIT count cycles; reaching TIMEOUT goes to ERR, which drives cpu_berr_n=0.
  - If rom_req is still up, ERR keeps it up, and the next rom_ack is discarded.
- ACK/ERR: hold cpu_dtack_n=0 (or cpu_berr_n=0) until cpu_as_n=1, then deassert on that edge and return to IDLE (busy=0). Never assert both strobes.
- Abort: cpu_as_n=1 before ACK.
  - From DECODE, WS_WAIT or PERIPH_WAIT: go to IDLE.
  - From ROM_WAIT: go to DRAIN, holding rom_req until rom_ack, then IDLE.
  - A new cycle starting while in DRAIN is not accepted until DRAIN exits.
- Back-to-back: AS high for one cycle then low again must start a new cycle; no lost cycles.
- rom_ack outside ROM_WAIT/DRAIN/ERR is ignored.
- Counters saturate, never wrap.

Decomposition:
- system_consts package gets:
  - region_t enum: REG_NONE, REG_ROM, REG_WORK, REG_SCREEN, REG_OBJECT, REG_COLOR, REG_IO, REG_SOUND, REG_EXT, REG_SS_SAVE, REG_SS_RESET, REG_SS_VEC.
  - bus_state_t.
- One sub-module, bus_region_encode: combinational priority encoder from the select lines to region_t.

Test Plan:
- ROM read at 0x000100, rom_ack 5 cycles after rom_req rises -> rom_addr=0x000100, rom_req high exactly until the ack cycle, dtack_n low 1 cycle after ack and held until AS rises.
- COLOR write with WS_COLOR=2 -> dtack_n low 3 cycles after DECODE; WORK read -> 2 cycles; unmapped 0x700000 -> 2 cycles, region=REG_NONE.
- SOUND read with periph_dtack_n never asserted -> berr_n low after 255 wait cycles, dtack_n stays 1, released when AS rises.
- ROM read aborted (AS high) 2 cycles after rom_req -> DRAIN; rom_req stays 1 until rom_ack, a new AS during DRAIN is delayed, and no dtack is issued for the aborted cycle.
- reset_n pulsed low mid ROM_WAIT -> rom_req, dtack_n=1, berr_n=1 immediately (async), IDLE after release.
- ss_reset_n and rom_sel_n both low -> region=REG_SS_RESET, no rom_req, dtack after WS_FAST.
